// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// master drives fields and out_ready; slave returns words and status.
interface instr_encoder_if #(
    parameter int XLEN       = 32,
    parameter int ILEN       = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_fmt;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic [XLEN-1:0] in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic            out_err;
    logic [CW-1:0]   count;

    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, count
    );

    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with range flagging and an output FIFO.
// Ports: clk, rst_n (sync, active low), bus (instr_encoder_if.slave).
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
endpackage

module instr_encoder #(
    parameter int XLEN       = rv32i_pkg::XLEN,
    parameter int ILEN       = rv32i_pkg::ILEN,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    instr_encoder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        FMT_I_ALU, FMT_I_LD, FMT_I_JALR, FMT_S,
        FMT_B, FMT_LUI, FMT_AUIPC, FMT_J
    } fmt_e;

    logic [XLEN-1:0] imm;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [ILEN-1:0] enc_instr;
    logic            enc_err;
    logic            is_shift;

    assign imm = bus.in_imm;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign f3  = bus.in_funct3;

    // funct3 001/101 are SLLI and SRLI/SRAI
    assign is_shift = (bus.in_fmt == FMT_I_ALU) && (f3[1:0] == 2'b01);

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        unique case (fmt_e'(bus.in_fmt))
            FMT_I_ALU, FMT_I_LD, FMT_I_JALR: begin
                if (is_shift) begin
                    enc_instr = {bus.in_funct7, imm[4:0], rs1, f3, rd,
                                 rv32i_pkg::OPCODE_OP_IMM};
                    enc_err   = |imm[XLEN-1:5];
                end else begin
                    enc_instr = {imm[11:0], rs1, f3, rd, 7'b0};
                    unique case (fmt_e'(bus.in_fmt))
                        FMT_I_LD:   enc_instr[6:0] = rv32i_pkg::OPCODE_LOAD;
                        FMT_I_JALR: enc_instr[6:0] = rv32i_pkg::OPCODE_JALR;
                        default:    enc_instr[6:0] = rv32i_pkg::OPCODE_OP_IMM;
                    endcase
                    enc_err = imm != {{(XLEN-12){imm[11]}}, imm[11:0]};
                end
            end
            FMT_S: begin
                enc_instr = {imm[11:5], rs2, rs1, f3, imm[4:0],
                             rv32i_pkg::OPCODE_STORE};
                enc_err   = imm != {{(XLEN-12){imm[11]}}, imm[11:0]};
            end
            FMT_B: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1],
                             imm[11], rv32i_pkg::OPCODE_BRANCH};
                enc_err   = imm[0] ||
                            (imm != {{(XLEN-13){imm[12]}}, imm[12:0]});
            end
            FMT_LUI: begin
                enc_instr = {imm[31:12], rd, rv32i_pkg::OPCODE_LUI};
                enc_err   = |imm[11:0];
            end
            FMT_AUIPC: begin
                enc_instr = {imm[31:12], rd, rv32i_pkg::OPCODE_AUIPC};
                enc_err   = |imm[11:0];
            end
            FMT_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd,
                             rv32i_pkg::OPCODE_JAL};
                enc_err   = imm[0] ||
                            (imm != {{(XLEN-21){imm[20]}}, imm[20:0]});
            end
        endcase
    end

    logic [ILEN-1:0] instr_q [FIFO_DEPTH];
    logic            err_q   [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready, out_valid, push, pop;

    // No bypass: a full FIFO refuses input even if it pops this cycle
    assign in_ready  = rst_n && (count_q < CW'(FIFO_DEPTH));
    assign out_valid = count_q != '0;
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // Pointers wrap naturally since FIFO_DEPTH is a power of two
    always_comb begin
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) begin
                instr_q[wptr_q] <= enc_instr;
                err_q[wptr_q]   <= enc_err;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_valid ? instr_q[rptr_q] : '0;
    assign bus.out_err   = out_valid ? err_q[rptr_q] : 1'b0;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Covers encodings, range flags, backpressure, wrap and reset.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.FIFO_DEPTH(4)) bus ();

    instr_encoder #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        bus.in_fmt    = fmt;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    // Single request through an empty FIFO with out_ready=1
    task automatic enc(input string tag, input logic [2:0] fmt,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_i, input logic exp_e);
        drive(fmt, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid = 1'b1;
        chk({tag, "_pre_valid"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_instr"}, bus.out_instr, exp_i);
        chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_e));
        @(posedge clk); #1;
        chk({tag, "_drain"}, 32'(bus.count), 32'd0);
    endtask

    task automatic push_word(input logic [31:0] imm);
        drive(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_err", 32'(bus.out_err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        bus.out_ready = 1'b1;
        enc("ialu_m1", 3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0,
            32'hFFFF_FFFF, 32'hFFF0_8113, 1'b0);
        enc("ialu_800", 3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0,
            32'h0000_0800, 32'h8000_8113, 1'b1);
        enc("b_8", 3'd4, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0,
            32'd8, 32'h0000_8463, 1'b0);
        enc("b_7", 3'd4, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0,
            32'd7, 32'h0000_8363, 1'b1);
        enc("b_1000", 3'd4, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0,
            32'h0000_1000, 32'h8000_8063, 1'b1);
        enc("lui_ok", 3'd5, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,
            32'h1234_5000, 32'h1234_5137, 1'b0);
        enc("lui_bad", 3'd5, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,
            32'h1234_5001, 32'h1234_5137, 1'b1);
        enc("j_800", 3'd7, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,
            32'h0000_0800, 32'h0010_016F, 1'b0);
        enc("srai_3", 3'd0, 5'd2, 5'd1, 5'd0, 3'd5, 7'h20,
            32'd3, 32'h4030_D113, 1'b0);
        enc("srai_32", 3'd0, 5'd2, 5'd1, 5'd0, 3'd5, 7'h20,
            32'd32, 32'h4000_D113, 1'b1);
        enc("sw_m4", 3'd3, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0,
            32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0);

        // Backpressure: fill, refuse, pop-without-push, then drain
        bus.out_ready = 1'b0;
        push_word(32'd1);
        push_word(32'd2);
        push_word(32'd3);
        push_word(32'd4);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("full_hold_count", 32'(bus.count), 32'd4);
        chk("full_head", bus.out_instr, 32'h0010_0093);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pop_only_count", 32'(bus.count), 32'd3);
        chk("pop_only_head", bus.out_instr, 32'h0020_0093);
        chk("pop_only_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("pushpop_count", 32'(bus.count), 32'd3);
        chk("pushpop_head", bus.out_instr, 32'h0030_0093);
        @(posedge clk); #1;
        chk("drain_w4", bus.out_instr, 32'h0040_0093);
        @(posedge clk); #1;
        chk("drain_w5", bus.out_instr, 32'h0050_0093);
        chk("drain_w5_count", 32'(bus.count), 32'd1);
        @(posedge clk); #1;
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Reset with three entries buffered
        bus.out_ready = 1'b0;
        push_word(32'd6);
        push_word(32'd7);
        push_word(32'd8);
        chk("mid_count", 32'(bus.count), 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_instr", bus.out_instr, 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_count", 32'(bus.count), 32'd0);
        enc("post_rst_j", 3'd7, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,
            32'h0000_0800, 32'h0010_016F, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator. Accepts decoded RV32I fields (format, registers, funct, full-width immediate) over a valid/ready input and packs them into 32-bit instruction words.
- Flags immediates that cannot be represented in the chosen format.
- Buffers encoded words in a small FIFO with a valid/ready output.
- Feeds instruction-memory preload and self-checking benches (encode, then decode, then compare).
- Uses the XLEN, ILEN and OPCODE_* constants from rv32i_pkg.

Parameters:
- XLEN, 32, immediate input width.
- ILEN, 32, instruction width.
- FIFO_DEPTH, 4, output buffer entries; power of 2, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept a request.
- in_fmt  in  3  format: 0 I_ALU, 1 I_LD, 2 I_JALR, 3 S, 4 B, 5 LUI, 6 AUIPC, 7 J.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; used only for I_ALU shifts.
- in_imm  in  XLEN  immediate, full signed/unsigned value.
- out_valid  out  1  out_instr/out_err valid.
- out_ready  in  1  consumer accepts the head entry.
- out_instr  out  ILEN  encoded instruction.
- out_err  out  1  immediate was not representable.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
Handshakes:
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < FIFO_DEPTH). There is no bypass: when full, in_ready=0 even if a pop occurs in the same cycle.
- Encoding is combinational on the input fields. On accept, {instr, err} is written to the FIFO tail.
- Latency: accept at edge N gives out_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- out_instr/out_err are driven from the FIFO head and held stable while out_valid && !out_ready.
- Simultaneous push and pop (not full): count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH.

Reset (rst_n=0 at an edge):
- count=0, out_valid=0, out_instr=0, out_err=0, pointers=0.
- in_ready=0 while rst_n=0, and 1 in the first cycle after release.
- Reset mid-stream discards all buffered entries. No partial output.

Packing (fields in brackets are imm bits):
- I_ALU/I_LD/I_JALR: {imm[11:0], rs1, funct3, rd, opcode}.
  - Exception: I_ALU with funct3=001 or 101 (shifts) packs {funct7, imm[4:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- LUI/AUIPC: {imm[31:12], rd, opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Opcode comes from the format; in_funct3 is ignored for U/J.

Range checks (out_err=1 if the check fails):
- I (non-shift) and S: imm equals sign-extension of imm[11:0].
- I_ALU shift: imm[31:5]==0.
- B: imm[0]==0 and imm equals sign-extension of imm[12:0].
- J: imm[0]==0 and imm equals sign-extension of imm[20:0].
- LUI/AUIPC: imm[11:0]==0.
- On error the word is still encoded from the truncated bits and enqueued. The error never blocks the handshake.

Test Plan:
- I_ALU rd=2 rs1=1 f3=0 imm=0xFFFFFFFF, out_ready=1 → out_instr=0xFFF08113, out_err=0, out_valid one cycle after accept. Same with imm=0x800 → out_err=1.
- B rs1=1 rs2=0 f3=0 imm=8 → 0x00008463, err=0. imm=7 → err=1. imm=0x1000 → err=1.
- LUI rd=2 imm=0x12345000 → 0x12345137, err=0. imm=0x12345001 → err=1. J rd=2 imm=0x800 → 0x0010016F, err=0.
- Shift: I_ALU f3=101 funct7=0x20 rd=2 rs1=1 imm=3 → 0x4030D113, err=0. imm=32 → err=1.
- Backpressure: out_ready=0, push 4 distinct words.
  - After the 4th push: count=4, in_ready=0; a 5th request with in_valid held is not accepted.
  - With full FIFO and out_ready=1 plus in_valid in the same cycle: the pop happens and the push does not.
  - Next cycle: in_ready=1; all 5 words emerge in order. Also exercises pointer wrap.
- Reset mid-stream with count=3: after the rst_n=0 edge, count=0 and out_valid=0. No stale words appear after release.
